outagu: RTL and testbench
=========================

OUTAGU -- requirements
Module: outagu

Interface
- REQ-001: Parameter BPREC, default 6, width of the precision port.
- REQ-002: Parameter BDBANKA, default 15, data bank address width.
- REQ-003: Parameter BLENGTH, default 15, length port width; each length value is the actual count minus 1.
- REQ-004: clk  in  1  sole clock; all state changes on the rising edge.
- REQ-005: clr  in  1  reset; asynchronous, active-high.
- REQ-006: start  in  1  one-cycle pulse; latches the configuration and begins a job.
- REQ-007: oprecision  in  BPREC  words (bit-planes) per output vector, P; the value 0 is treated as 1.
- REQ-008: obaseaddr  in  BDBANKA  address of the first output vector.
- REQ-009: ostride0/ostride1/ostride2  in  BDBANKA each  address increments for dimensions 0, 1 and 2.
- REQ-010: olength0/olength1/olength2  in  BLENGTH each  vector counts minus 1 for dimensions 0, 1 and 2.
- REQ-011: qvalid  in  1  quantizer output word is available.
- REQ-012: qready  out  1  block accepts a quantizer word.
- REQ-013: wrd_en  out  1  data memory write request.
- REQ-014: wrd_grnt  in  1  data memory write grant.
- REQ-015: wrd_addr  out  BDBANKA  data memory write address.
- REQ-016: busy  out  1  job in progress.
- REQ-017: done  out  1  one-cycle pulse at job completion.

Function
- REQ-018: The FSM SHALL have the states IDLE, WAIT, WRITE and DONE; the outputs SHALL be registered or decoded directly from the state.
- REQ-019: The configuration SHALL be sampled only on the cycle start=1; input changes at other times SHALL have no effect on a running job.
- REQ-020: start=1 in any state SHALL load the counters (b=0, c0=c1=c2=0), set vaddr=obaseaddr and wrd_addr=obaseaddr, and enter WAIT on the next cycle.
- REQ-021: qready SHALL be 1 only in WAIT, and busy SHALL be 1 in WAIT and WRITE.
- REQ-022: In WAIT, qvalid=1 SHALL complete the handshake and enter WRITE on the next cycle, giving a one-cycle latency from accept to wrd_en.
- REQ-023: wrd_en SHALL be 1 only in WRITE, and wrd_addr SHALL stay stable until the cycle in which wrd_grnt=1.
- REQ-024: A grant while b<P-1 SHALL set b++ and wrd_addr=vaddr+b+1, then return to WAIT.
- REQ-025: A grant on the last bit-plane (b=P-1) of a vector SHALL set b=0 and advance the vector pointer as follows:
  - c0<olength0: c0++, vaddr+=ostride0.
  - else, if c1<olength1: c0=0, c1++, vaddr+=ostride1.
  - else, if c2<olength2: c0=c1=0, c2++, vaddr+=ostride2.
  - else: the job is finished and the FSM SHALL enter DONE.
  - In every non-finishing case, wrd_addr SHALL take the new vaddr and the FSM SHALL return to WAIT.
- REQ-026: DONE SHALL assert done=1 for exactly one cycle, then go to IDLE; wrd_addr SHALL hold its last value.
- REQ-027: All address arithmetic SHALL be modulo 2^BDBANKA with silent wrap-around.
- REQ-028: The total number of writes per job SHALL equal P*(olength0+1)*(olength1+1)*(olength2+1).
- REQ-029: start asserted together with wrd_grnt SHALL abort the current job; the grant SHALL be ignored and no done SHALL be issued for the aborted job.
- REQ-030: start during DONE SHALL suppress the transition to IDLE in favour of WAIT, while done is still pulsed that cycle.
- REQ-031: qvalid SHALL be ignored in IDLE, WRITE and DONE.

Reset
- REQ-032: clr=1 SHALL immediately force state=IDLE and set qready=0, wrd_en=0, busy=0, done=0, wrd_addr=0 and all counters and vaddr to 0, independent of clk.
- REQ-033: clr deassertion SHALL NOT start a job; a start pulse SHALL be required.
- REQ-034: clr asserted mid-job SHALL abandon the job with no done pulse.

Configuration
- REQ-035: With macro OUTAGU_STALLCNT_EN defined, the block SHALL have the output stallcnt [15:0], and the following rules SHALL apply:
  - stallcnt SHALL be cleared by clr and by start.
  - stallcnt SHALL increment every cycle with wrd_en=1 and wrd_grnt=0, saturating at 16'hFFFF.
- REQ-036: Without OUTAGU_STALLCNT_EN, the stallcnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
- REQ-037: Reset check: clr=1 mid-WRITE -> the same cycle gives wrd_en=0, busy=0, wrd_addr=0; no done pulse follows.
- REQ-038: Basic job: obaseaddr=0x0100, P=2, olength0=2, ostride0=4, olength1=olength2=0, grant always 1 -> addresses 0x100, 0x101, 0x104, 0x105, 0x108, 0x109, then done pulses once, then busy=0.
- REQ-039: Multi-dimension job: base=0, P=1, olength0=1, olength1=1, olength2=0, ostride0=1, ostride1=0x10 -> addresses 0x000, 0x001, 0x011, 0x012, then done.
- REQ-040: Grant stall: hold wrd_grnt=0 for 5 cycles in WRITE -> wrd_en=1, wrd_addr constant and qready=0 throughout; with OUTAGU_STALLCNT_EN, stallcnt=5.
- REQ-041: Address wrap: base=0x7FFE, P=4, one vector -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- REQ-042: Restart: start with base=0x0200 during the third write of a job -> next address is 0x0200, and exactly one done pulse occurs, from the new job only.

Source files
------------

// File: rtl/outagu_if.sv
// Output address generator bus bundle: quantizer handshake plus data memory
// write request/grant. The "master" side belongs to outagu, which accepts
// quantizer words and issues writes. The "slave" side belongs to the
// environment: the quantizer and the memory arbiter.
interface outagu_if #(
  parameter int BDBANKA = 15
);
  logic               qvalid;
  logic               qready;
  logic               wrd_en;
  logic               wrd_grnt;
  logic [BDBANKA-1:0] wrd_addr;

  modport master (
    input  qvalid,
    input  wrd_grnt,
    output qready,
    output wrd_en,
    output wrd_addr
  );

  modport slave (
    output qvalid,
    output wrd_grnt,
    input  qready,
    input  wrd_en,
    input  wrd_addr
  );
endinterface

// File: rtl/outagu.sv
// outagu -- output address generator.
// Walks up to three nested vector dimensions. For each vector it accepts P
// quantizer words, one per bit-plane, and writes each of them to consecutive
// addresses starting at the vector address. Vector addresses accumulate
// per-dimension strides. The stride of the dimension that advances is added
// to the running address; the address is never recomputed from the counters.
// Optional feature: define OUTAGU_STALLCNT_EN to add the 16-bit saturating
// stallcnt output. It counts the cycles in which a write request waits
// for a grant.
module outagu #(
  parameter int BPREC   = 6,
  parameter int BDBANKA = 15,
  parameter int BLENGTH = 15
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [BPREC-1:0]   oprecision,
  input  logic [BDBANKA-1:0] obaseaddr,
  input  logic [BDBANKA-1:0] ostride0,
  input  logic [BDBANKA-1:0] ostride1,
  input  logic [BDBANKA-1:0] ostride2,
  input  logic [BLENGTH-1:0] olength0,
  input  logic [BLENGTH-1:0] olength1,
  input  logic [BLENGTH-1:0] olength2,
  outagu_if.master           bus,
`ifdef OUTAGU_STALLCNT_EN
  output logic [15:0]        stallcnt,
`endif
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

  state_t             state_q;
  logic [BPREC-1:0]   pm1_q;
  logic [BDBANKA-1:0] str0_q, str1_q, str2_q;
  logic [BLENGTH-1:0] len0_q, len1_q, len2_q;
  logic [BPREC-1:0]   b_q;
  logic [BLENGTH-1:0] c0_q, c1_q, c2_q;
  logic [BDBANKA-1:0] vaddr_q;
  logic [BDBANKA-1:0] wrd_addr_q;
  logic               qready_q, wrd_en_q, busy_q, done_q;

  logic [BLENGTH-1:0] c0_d, c1_d, c2_d;
  logic [BDBANKA-1:0] vaddr_d;
  logic [BDBANKA-1:0] plane_addr_d;
  logic               last_plane_d;
  logic               job_end_d;

  // Next bit-plane address and next vector pointer (innermost dimension first)
  always_comb begin
    last_plane_d = (b_q == pm1_q);
    plane_addr_d = vaddr_q + BDBANKA'(b_q) + BDBANKA'(1);
    c0_d         = c0_q;
    c1_d         = c1_q;
    c2_d         = c2_q;
    vaddr_d      = vaddr_q;
    job_end_d    = 1'b0;
    if (c0_q < len0_q) begin
      c0_d    = c0_q + BLENGTH'(1);
      vaddr_d = vaddr_q + str0_q;
    end else if (c1_q < len1_q) begin
      c0_d    = '0;
      c1_d    = c1_q + BLENGTH'(1);
      vaddr_d = vaddr_q + str1_q;
    end else if (c2_q < len2_q) begin
      c0_d    = '0;
      c1_d    = '0;
      c2_d    = c2_q + BLENGTH'(1);
      vaddr_d = vaddr_q + str2_q;
    end else begin
      job_end_d = 1'b1;
    end
  end

  // Job FSM. All outputs are registered alongside the state; start overrides everything
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      pm1_q      <= '0;
      str0_q     <= '0;
      str1_q     <= '0;
      str2_q     <= '0;
      len0_q     <= '0;
      len1_q     <= '0;
      len2_q     <= '0;
      b_q        <= '0;
      c0_q       <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
      vaddr_q    <= '0;
      wrd_addr_q <= '0;
      qready_q   <= 1'b0;
      wrd_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (start) begin
      // A precision of 0 is stored as P-1 = 0, i.e. it behaves as P = 1
      pm1_q      <= (oprecision == '0) ? '0 : oprecision - BPREC'(1);
      str0_q     <= ostride0;
      str1_q     <= ostride1;
      str2_q     <= ostride2;
      len0_q     <= olength0;
      len1_q     <= olength1;
      len2_q     <= olength2;
      b_q        <= '0;
      c0_q       <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
      vaddr_q    <= obaseaddr;
      wrd_addr_q <= obaseaddr;
      state_q    <= WAIT;
      qready_q   <= 1'b1;
      wrd_en_q   <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        WAIT: begin
          if (bus.qvalid) begin
            state_q  <= WRITE;
            qready_q <= 1'b0;
            wrd_en_q <= 1'b1;
          end
        end
        WRITE: begin
          if (bus.wrd_grnt) begin
            wrd_en_q <= 1'b0;
            if (!last_plane_d) begin
              b_q        <= b_q + BPREC'(1);
              wrd_addr_q <= plane_addr_d;
              state_q    <= WAIT;
              qready_q   <= 1'b1;
            end else begin
              b_q <= '0;
              if (job_end_d) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                c0_q       <= c0_d;
                c1_q       <= c1_d;
                c2_q       <= c2_d;
                vaddr_q    <= vaddr_d;
                wrd_addr_q <= vaddr_d;
                state_q    <= WAIT;
                qready_q   <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.qready   = qready_q;
  assign bus.wrd_en   = wrd_en_q;
  assign bus.wrd_addr = wrd_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef OUTAGU_STALLCNT_EN
  logic [15:0] stall_q;

  // Count ungranted write-request cycles, saturating; a new job restarts the count
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_q <= '0;
    end else if (start) begin
      stall_q <= '0;
    end else if (wrd_en_q && !bus.wrd_grnt && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stallcnt = stall_q;
`endif

endmodule

// File: tb/tb_outagu.sv
// Self-checking bench for outagu: directed vector table, hand-written corner
// sequences and randomized jobs against an address-list reference model.
module tb_outagu;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [5:0]  oprecision;
  logic [14:0] obaseaddr, ostride0, ostride1, ostride2;
  logic [14:0] olength0, olength1, olength2;
  logic        busy, done;
`ifdef OUTAGU_STALLCNT_EN
  logic [15:0] stallcnt;
`endif

  outagu_if #(.BDBANKA(15)) bus ();

  outagu #(.BPREC(6), .BDBANKA(15), .BLENGTH(15)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .oprecision (oprecision),
    .obaseaddr  (obaseaddr),
    .ostride0   (ostride0),
    .ostride1   (ostride1),
    .ostride2   (ostride2),
    .olength0   (olength0),
    .olength1   (olength1),
    .olength2   (olength2),
    .bus        (bus),
`ifdef OUTAGU_STALLCNT_EN
    .stallcnt   (stallcnt),
`endif
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [14:0] exp_q[$];
  logic [14:0] last_wr;

  typedef struct {
    logic [14:0] base;
    int          p, l0, l1, l2;
    logic [14:0] s0, s1, s2;
    int          n;
    logic [14:0] a [8];
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected write-address list. Vectors are numbered in walk order. After
  // vector v, the stride added is that of the innermost dimension whose index
  // does not wrap.
  task automatic build_model(input logic [14:0] base, input int p, input int l0, input int l1,
                             input int l2, input logic [14:0] s0, input logic [14:0] s1,
                             input logic [14:0] s2);
    logic [14:0] va;
    int np, n0, n1, n2;
    exp_q.delete();
    np = (p == 0) ? 1 : p;
    n0 = l0 + 1;
    n1 = l1 + 1;
    n2 = l2 + 1;
    va = base;
    for (int v = 0; v < n0 * n1 * n2; v++) begin
      for (int b = 0; b < np; b++) exp_q.push_back(15'(va + 15'(b)));
      if (((v + 1) % n0) != 0)               va = 15'(va + s0);
      else if ((((v + 1) / n0) % n1) != 0)   va = 15'(va + s1);
      else                                   va = 15'(va + s2);
    end
  endtask

  task automatic start_job(input logic [14:0] base, input int p, input int l0, input int l1,
                           input int l2, input logic [14:0] s0, input logic [14:0] s1,
                           input logic [14:0] s2);
    oprecision = 6'(p);
    obaseaddr  = base;
    olength0   = 15'(l0);
    olength1   = 15'(l1);
    olength2   = 15'(l2);
    ostride0   = s0;
    ostride1   = s1;
    ostride2   = s2;
    start      = 1'b1;
    step();
    start = 1'b0;
    // Configuration changes after start must not disturb the running job
    oprecision = 6'($urandom);
    obaseaddr  = 15'($urandom);
    olength0   = 15'($urandom);
    olength1   = 15'($urandom);
    olength2   = 15'($urandom);
    ostride0   = 15'($urandom);
    ostride1   = 15'($urandom);
    ostride2   = 15'($urandom);
    chk("start busy", busy, 1);
    chk("start qready", bus.qready, 1);
    chk("start wrd_addr", bus.wrd_addr, base);
  endtask

  task automatic run_to_done(input int qv, input int gr, input string tag);
    int          cyc;
    logic        stalled;
    logic [14:0] prev;
    logic [14:0] e;
    cyc = 0;
    stalled = 1'b0;
    prev = '0;
    while (!done && cyc < 3000) begin
      if (stalled) begin
        chk({tag, " stall wrd_en"}, bus.wrd_en, 1);
        chk({tag, " stall wrd_addr"}, bus.wrd_addr, prev);
      end
      bus.qvalid   = ($urandom_range(99) < qv);
      bus.wrd_grnt = ($urandom_range(99) < gr);
      if (bus.wrd_en && bus.wrd_grnt) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s extra write: got addr %0h, expected no write", tag, bus.wrd_addr);
        end else begin
          e = exp_q.pop_front();
          chk({tag, " wrd_addr"}, bus.wrd_addr, e);
        end
        last_wr = bus.wrd_addr;
      end
      stalled = bus.wrd_en && !bus.wrd_grnt;
      prev    = bus.wrd_addr;
      step();
      cyc++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: done=%0d after %0d cycles, expected 1", tag, done, cyc);
    end
    chk({tag, " writes left"}, exp_q.size(), 0);
    bus.qvalid   = 1'b0;
    bus.wrd_grnt = 1'b0;
  endtask

  // Called in the DONE cycle: one-cycle done, address held, quiet IDLE after
  task automatic post_done(input string tag);
    chk({tag, " busy in DONE"}, busy, 0);
    chk({tag, " addr hold"}, bus.wrd_addr, last_wr);
    bus.qvalid = 1'b1;
    step();
    chk({tag, " done one cycle"}, done, 0);
    chk({tag, " busy idle"}, busy, 0);
    step();
    chk({tag, " idle qready"}, bus.qready, 0);
    chk({tag, " idle wrd_en"}, bus.wrd_en, 0);
    bus.qvalid = 1'b0;
  endtask

  initial begin
    vec_t tbl [5];
    int   nwr;
    int   cyc;
    logic [14:0] a0;

    tbl[0] = '{15'h0100, 2, 2, 0, 0, 15'd4, 15'd0, 15'd0, 6,
               '{15'h100, 15'h101, 15'h104, 15'h105, 15'h108, 15'h109, 15'h0, 15'h0}};
    tbl[1] = '{15'h0000, 1, 1, 1, 0, 15'd1, 15'h10, 15'd0, 4,
               '{15'h000, 15'h001, 15'h011, 15'h012, 15'h0, 15'h0, 15'h0, 15'h0}};
    tbl[2] = '{15'h7FFE, 4, 0, 0, 0, 15'd0, 15'd0, 15'd0, 4,
               '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001, 15'h0, 15'h0, 15'h0, 15'h0}};
    tbl[3] = '{15'h0020, 0, 2, 0, 0, 15'd3, 15'd0, 15'd0, 3,
               '{15'h020, 15'h023, 15'h026, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0}};
    tbl[4] = '{15'h0010, 1, 0, 1, 1, 15'd5, 15'd2, 15'h100, 4,
               '{15'h010, 15'h012, 15'h112, 15'h114, 15'h0, 15'h0, 15'h0, 15'h0}};

    clr = 1'b1;
    start = 1'b0;
    oprecision = '0;
    obaseaddr = '0;
    ostride0 = '0;
    ostride1 = '0;
    ostride2 = '0;
    olength0 = '0;
    olength1 = '0;
    olength2 = '0;
    bus.qvalid = 1'b0;
    bus.wrd_grnt = 1'b0;
    last_wr = '0;

    // Reset state
    #2;
    chk("reset qready", bus.qready, 0);
    chk("reset wrd_en", bus.wrd_en, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset wrd_addr", bus.wrd_addr, 0);
    step();
    step();
    clr = 1'b0;
    bus.qvalid = 1'b1;
    repeat (3) step();
    chk("no job after clr release", busy, 0);
    bus.qvalid = 1'b0;

    // Directed vector table, always-ready quantizer and memory
    for (int i = 0; i < 5; i++) begin
      exp_q.delete();
      for (int j = 0; j < tbl[i].n; j++) exp_q.push_back(tbl[i].a[j]);
      start_job(tbl[i].base, tbl[i].p, tbl[i].l0, tbl[i].l1, tbl[i].l2,
                tbl[i].s0, tbl[i].s1, tbl[i].s2);
      run_to_done(100, 100, $sformatf("tbl%0d", i));
      post_done($sformatf("tbl%0d", i));
    end

    // Grant stall: five ungranted cycles in WRITE
    build_model(15'h0300, 1, 0, 0, 0, 15'd0, 15'd0, 15'd0);
    start_job(15'h0300, 1, 0, 0, 0, 15'd0, 15'd0, 15'd0);
    bus.qvalid = 1'b1;
    bus.wrd_grnt = 1'b0;
    cyc = 0;
    while (!bus.wrd_en && cyc < 10) begin
      step();
      cyc++;
    end
    bus.qvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall wrd_en", bus.wrd_en, 1);
      chk("stall wrd_addr", bus.wrd_addr, 15'h0300);
      chk("stall qready", bus.qready, 0);
      step();
    end
`ifdef OUTAGU_STALLCNT_EN
    chk("stallcnt", stallcnt, 5);
`endif
    bus.wrd_grnt = 1'b1;
    last_wr = bus.wrd_addr;
    step();
    bus.wrd_grnt = 1'b0;
    chk("stall job done", done, 1);
    post_done("stall");

    // Reset in the middle of WRITE
    start_job(15'h0400, 2, 3, 0, 0, 15'd8, 15'd0, 15'd0);
    bus.qvalid = 1'b1;
    cyc = 0;
    while (!bus.wrd_en && cyc < 10) begin
      step();
      cyc++;
    end
    bus.qvalid = 1'b0;
    chk("pre-clr wrd_en", bus.wrd_en, 1);
    clr = 1'b1;
    #1;
    chk("clr wrd_en", bus.wrd_en, 0);
    chk("clr busy", busy, 0);
    chk("clr wrd_addr", bus.wrd_addr, 0);
    chk("clr qready", bus.qready, 0);
    step();
    clr = 1'b0;
    bus.qvalid = 1'b1;
    bus.wrd_grnt = 1'b1;
    nwr = 0;
    for (int k = 0; k < 8; k++) begin
      if (done || busy) nwr++;
      step();
    end
    chk("no activity after clr", nwr, 0);
    bus.qvalid = 1'b0;
    bus.wrd_grnt = 1'b0;

    // Restart during the third write; the colliding grant is dropped
    start_job(15'h0100, 1, 5, 0, 0, 15'd1, 15'd0, 15'd0);
    bus.qvalid = 1'b1;
    bus.wrd_grnt = 1'b1;
    nwr = 0;
    cyc = 0;
    a0 = '0;
    while (!(bus.wrd_en && nwr == 2) && cyc < 40) begin
      chk("restart old done", done, 0);
      if (bus.wrd_en) begin
        chk("restart old addr", bus.wrd_addr, 15'(15'h0100 + 15'(nwr)));
        nwr++;
      end
      step();
      cyc++;
    end
    chk("restart third write addr", bus.wrd_addr, 15'h0102);
    build_model(15'h0200, 1, 1, 0, 0, 15'd1, 15'd0, 15'd0);
    start_job(15'h0200, 1, 1, 0, 0, 15'd1, 15'd0, 15'd0);
    chk("restart done", done, 0);
    run_to_done(100, 100, "restart");
    post_done("restart");

    // start during DONE: done still pulses, next state WAIT
    build_model(15'h0050, 1, 0, 0, 0, 15'd0, 15'd0, 15'd0);
    start_job(15'h0050, 1, 0, 0, 0, 15'd0, 15'd0, 15'd0);
    run_to_done(100, 100, "donestart A");
    chk("donestart done pulse", done, 1);
    build_model(15'h0060, 2, 1, 0, 0, 15'd7, 15'd0, 15'd0);
    start_job(15'h0060, 2, 1, 0, 0, 15'd7, 15'd0, 15'd0);
    chk("donestart done cleared", done, 0);
    run_to_done(70, 70, "donestart B");
    post_done("donestart B");

    // Randomized jobs against the reference model
    for (int r = 0; r < 20; r++) begin
      logic [14:0] rb, r0, r1, r2;
      int rp, rl0, rl1, rl2;
      rb  = 15'($urandom);
      r0  = 15'($urandom);
      r1  = 15'($urandom);
      r2  = 15'($urandom);
      rp  = $urandom_range(3);
      rl0 = $urandom_range(2);
      rl1 = $urandom_range(2);
      rl2 = $urandom_range(2);
      build_model(rb, rp, rl0, rl1, rl2, r0, r1, r2);
      start_job(rb, rp, rl0, rl1, rl2, r0, r1, r2);
      run_to_done(60, 60, $sformatf("rand%0d", r));
      post_done($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
